// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// plab4_net_router_output_ctrl_pkg
//   Shared definitions for the ring-router output controller:
//   - route codes produced by the greedy route-compute stage
//   - output-controller FSM state encodings
//   - small mod-3 helpers for the three-input round-robin pointer
// -----------------------------------------------------------------------------
package plab4_net_router_output_ctrl_pkg;

    // Route codes (shared with the route-compute stage)
    localparam logic [1:0] ROUTE_PREV = 2'b00;
    localparam logic [1:0] ROUTE_NEXT = 2'b01;
    localparam logic [1:0] ROUTE_TERM = 2'b10;
    localparam logic [1:0] ROUTE_NONE = 2'b11;  // never matches any output

    // Output controller FSM states
    localparam logic FSM_IDLE = 1'b0;
    localparam logic FSM_HOLD = 1'b1;

    // Input index increment, wrapping 2 -> 0. A stray 3 maps back to 0.
    function automatic logic [1:0] inc_mod3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // One-hot encode an input index (index 3 has no input -> zero).
    function automatic logic [2:0] onehot3(input logic [1:0] x);
        logic [2:0] r;
        case (x)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_round_robin_arb3.sv
// -----------------------------------------------------------------------------
// plab4_net_router_output_ctrl_round_robin_arb3
//   Purely combinational 3-way round-robin arbiter. Search starts at prio_ptr
//   and proceeds prio_ptr+1, prio_ptr+2 (mod 3); first requester wins.
//
// Ports:
//   req        in  3  request per input
//   prio_ptr   in  2  highest-priority input index (0..2)
//   grant      out 3  one-hot winner (zero when no request)
//   grant_idx  out 2  winner index (0 when no request)
//   grant_val  out 1  any request present
// -----------------------------------------------------------------------------
module plab4_net_router_output_ctrl_round_robin_arb3
    import plab4_net_router_output_ctrl_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] prio_ptr,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_val
);

    always_comb begin
        logic [1:0] cand;
        cand      = (prio_ptr == 2'd3) ? 2'd0 : prio_ptr;
        grant_val = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!grant_val && req[cand]) begin
                grant_val = 1'b1;
                grant_idx = cand;
            end
            cand = inc_mod3(cand);
        end
        grant = grant_val ? onehot3(grant_idx) : 3'b000;
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// -----------------------------------------------------------------------------
// plab4_net_router_output_ctrl
//   Output-port controller for one output of a one-way ring router. Arbitrates
//   among prev/next/term inputs whose route code targets this output, drives
//   the crossbar select and the val/rdy handshake downstream. Grants are
//   round-robin and held (HOLD state) until the downstream handshake completes.
//
// Ports:
//   clk       in  1  clock
//   reset     in  1  synchronous active-high reset
//   domain    in  1  security label only; no effect on logic
//   in_val    in  3  per-input valid (0=prev, 1=next, 2=term)
//   in_route  in  6  per-input route code, bits [2i+1:2i] for input i
//   out_rdy   in  1  downstream ready
//   out_val   out 1  downstream valid
//   xbar_sel  out 2  crossbar select = granted input index
//   grants    out 3  one-hot transfer strobe per input (zero if no transfer)
// -----------------------------------------------------------------------------
module plab4_net_router_output_ctrl
    import plab4_net_router_output_ctrl_pkg::*;
#(
    parameter logic [1:0] p_output_port = ROUTE_NEXT,
    parameter int         p_num_inputs  = 3
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      domain,
    input  logic [p_num_inputs-1:0]   in_val,
    input  logic [2*p_num_inputs-1:0] in_route,
    input  logic                      out_rdy,
    output logic                      out_val,
    output logic [1:0]                xbar_sel,
    output logic [p_num_inputs-1:0]   grants
);

    // Label-only input; keep it connected so the port is not flagged dangling.
    logic unused_domain;
    assign unused_domain = domain;

    // Per-input request for this output
    logic [2:0] req;
    for (genvar i = 0; i < 3; i++) begin : g_req
        assign req[i] = in_val[i] && (in_route[2*i +: 2] == p_output_port);
    end

    // State
    logic       fsm,        fsm_next;
    logic [1:0] prio_ptr,   prio_ptr_next;
    logic [1:0] locked_sel, locked_sel_next;

    // Round-robin winner for the IDLE state
    logic [2:0] arb_grant;
    logic [1:0] arb_idx;
    logic       arb_val;

    plab4_net_router_output_ctrl_round_robin_arb3 u_arb (
        .req       (req),
        .prio_ptr  (prio_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_val (arb_val)
    );

    logic locked_req;
    assign locked_req = req[locked_sel];

    always_comb begin
        out_val         = 1'b0;
        xbar_sel        = 2'd0;
        grants          = '0;
        fsm_next        = fsm;
        prio_ptr_next   = prio_ptr;
        locked_sel_next = locked_sel;

        // Outputs are forced quiet during reset; state is cleared in always_ff.
        if (!reset) begin
            if (fsm == FSM_IDLE) begin
                if (arb_val) begin
                    out_val  = 1'b1;
                    xbar_sel = arb_idx;
                    if (out_rdy) begin
                        grants        = arb_grant;
                        prio_ptr_next = inc_mod3(arb_idx);
                    end else begin
                        // Downstream stalled: lock this winner until it drains
                        locked_sel_next = arb_idx;
                        fsm_next        = FSM_HOLD;
                    end
                end
            end else begin
                // HOLD: the locked input owns the output regardless of others
                out_val  = locked_req;
                xbar_sel = locked_sel;
                if (!locked_req) begin
                    // Upstream withdrew valid: abandon the lock, no transfer,
                    // pointer left where it was.
                    fsm_next = FSM_IDLE;
                end else if (out_rdy) begin
                    grants        = onehot3(locked_sel);
                    prio_ptr_next = inc_mod3(locked_sel);
                    fsm_next      = FSM_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= FSM_IDLE;
            prio_ptr   <= 2'd0;
            locked_sel <= 2'd0;
        end else begin
            fsm        <= fsm_next;
            prio_ptr   <= prio_ptr_next;
            locked_sel <= locked_sel_next;
        end
    end

endmodule

// File: doc/plab4_net_router_output_ctrl.md
Name: plab4_net_router_output_ctrl

Overview:
Output-port controller for one output of a one-way ring router. It consumes the per-input route codes produced by the greedy route-compute stage and arbitrates among the three router inputs (prev, next, terminal) that target this output. It drives the crossbar select and the val/rdy handshake toward the downstream channel. Grants are round-robin fair and held stable until the downstream handshake completes.

Parameters:
p_output_port, 2'b01, route code this instance serves: 2'b00 PREV, 2'b01 NEXT, 2'b10 TERM.
p_num_inputs, 3, number of router inputs; fixed at 3 (0=prev, 1=next, 2=term).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
domain  input  1  security label; every other port and all internal state carry label {Domain domain}
in_val  input  3  valid per router input (bit i = input i)
in_route  input  6  route code per input; bits [2i+1:2i] belong to input i
out_rdy  input  1  downstream channel ready
out_val  output  1  downstream channel valid
xbar_sel  output  2  crossbar select, equal to the index of the granted input
grants  output  3  one-hot; bit i high means input i's message transfers this cycle (the router ANDs it into in_rdy)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Request: req[i] = in_val[i] && (in_route[i] == p_output_port). Route code 2'b11 never matches.
- State: fsm in {IDLE, HOLD}; prio_ptr (2b, range 0..2); locked_sel (2b).
- Reset: fsm=IDLE, prio_ptr=0, locked_sel=0. Outputs in the reset cycle: out_val=0, grants=0, xbar_sel=0. Reset asserted while in HOLD returns to IDLE and drops the lock.
- IDLE winner: round-robin, combinational, zero-cycle latency. Search order is prio_ptr, prio_ptr+1, prio_ptr+2 (mod 3); the first req wins.
- IDLE with no req: out_val=0, grants=0, xbar_sel=0; state unchanged.
- IDLE with a winner w: out_val=1, xbar_sel=w.
  - out_rdy=1: grants=onehot(w); prio_ptr <= (w+1) mod 3; stay IDLE.
  - out_rdy=0: grants=0; locked_sel <= w; go to HOLD.
- HOLD: the winner is locked_sel regardless of other requests; out_val=req[locked_sel]; xbar_sel=locked_sel.
  - out_rdy=1 and req[locked_sel]=1: grants=onehot(locked_sel); prio_ptr <= locked_sel+1 mod 3; go to IDLE.
  - req[locked_sel]=0 (protocol violation: upstream withdrew valid): out_val=0, grants=0, no transfer; go to IDLE; prio_ptr unchanged.
- Width and arithmetic: the pointer increment wraps 2 -> 0; value 3 is never stored.
- grants is always one-hot or zero; grants!=0 implies out_val && out_rdy.
- Single-flit messages only; no multi-cycle packet lock beyond HOLD.
- domain is not used in control logic. It only labels signals for the type checker.

Decomposition:
- Shared include (plab4-net-RouteCodes): ROUTE_PREV, ROUTE_NEXT, ROUTE_TERM macros. The route-compute stage and this block both use it.
- Sub-module round_robin_arb3: inputs req[2:0], prio_ptr; outputs a one-hot winner and a winner index. Purely combinational. The FSM and pointer stay in the parent.

Test Plan:
- Reset: hold reset 2 cycles with in_val=3'b111 and all routes matching -> out_val=0, grants=0, xbar_sel=0 every reset cycle; the first post-reset transfer grants input 0.
- Fairness: out_rdy=1, all three inputs continuously request this port -> grant sequence 001, 010, 100, 001 on consecutive cycles; xbar_sel 0,1,2,0.
- Route filter: p_output_port=NEXT, in_val=3'b111, routes {TERM, PREV, NEXT} for inputs {2,1,0} -> only input 0 is granted; a code of 2'b11 on any input is never granted.
- Backpressure hold: input 1 wins, then out_rdy=0 for 3 cycles while input 2 also requests -> out_val=1, xbar_sel=1, grants=0 for 3 cycles; out_rdy rises -> grants=010; the next cycle's winner is input 2.
- Withdraw and mid-HOLD reset: in HOLD on input 2, drop in_val[2] -> out_val=0 the same cycle, IDLE next cycle, prio_ptr unchanged. Separately, assert reset in HOLD -> IDLE with prio_ptr=0 on the following cycle.
